// File: rtl/i2c_pkg.sv
// Shared types for the I2C requester arbiter: FSM states, latched request fields, retry width.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [6:0] daddr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wen;
    } i2c_req_t;

    localparam int I2C_ARB_RETRY_W = 4;

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin picker: first set request scanning ptr+1, ptr+2, ... modulo NREQ.
module i2c_rr_pick #(
    parameter int  NREQ = 4,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   ptr_i,
    output logic            any_o,
    output logic [GW-1:0]   idx_o
);

    logic [GW-1:0] w_k;

    // Walk from the farthest position back to the nearest so the nearest set bit wins.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        w_k   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_k = GW'((int'(ptr_i) + i) % NREQ);
            if (req_i[w_k]) begin
                idx_o = w_k;
            end
        end
    end

endmodule

// File: rtl/i2c_arb.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters, one transaction at a time.
// Optional NACK retry is enabled by defining I2C_ARB_RETRY_EN.
module i2c_arb
    import i2c_pkg::*;
#(
    parameter int  NREQ      = 4,
    parameter int  MAX_RETRY = 3,
    localparam int GW        = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_val_i,
    input  logic [NREQ-1:0][6:0] req_daddr_i,
    input  logic [NREQ-1:0][7:0] req_addr_i,
    input  logic [NREQ-1:0][7:0] req_data_i,
    input  logic [NREQ-1:0]      req_wen_i,
    output logic [NREQ-1:0]      req_rdy_o,
    output logic [NREQ-1:0]      rsp_val_o,
    output logic                 rsp_err_o,
    output logic [7:0]           rsp_data_o,
    input  logic [NREQ-1:0]      rsp_rdy_i,
    output logic                 m_val_o,
    output logic [6:0]           m_daddr_o,
    output logic [7:0]           m_addr_o,
    output logic [7:0]           m_data_o,
    output logic                 m_wen_o,
    input  logic                 m_rdy_i,
    input  logic                 m_val_i,
    input  logic                 m_err_i,
    input  logic [7:0]           m_data_i,
    output logic                 m_rdy_o,
    output logic                 busy_o,
    output logic [GW-1:0]        grant_o
);

    if (NREQ < 2) begin : g_chk_nreq
        $error("i2c_arb: NREQ must be at least 2");
    end
    if (MAX_RETRY >= (1 << I2C_ARB_RETRY_W)) begin : g_chk_retry
        $error("i2c_arb: MAX_RETRY does not fit the retry counter");
    end

    arb_state_e    r_state, w_next;
    i2c_req_t      r_req;
    logic [GW-1:0] r_grant, r_ptr;
    logic          r_err;
    logic [7:0]    r_data;
    logic          w_any, w_retry;
    logic [GW-1:0] w_pick;

    i2c_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (req_val_i),
        .ptr_i (r_ptr),
        .any_o (w_any),
        .idx_o (w_pick)
    );

`ifdef I2C_ARB_RETRY_EN
    logic [I2C_ARB_RETRY_W-1:0] r_cnt;
    assign w_retry = m_err_i && (r_cnt < I2C_ARB_RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_cnt <= '0;
        end else if (r_state == WAIT && m_val_i && w_retry) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any)                w_next = ISSUE;
            ISSUE:   if (m_rdy_i)              w_next = WAIT;
            WAIT:    if (m_val_i)              w_next = w_retry ? ISSUE : RESP;
            RESP:    if (rsp_rdy_i[r_grant])   w_next = IDLE;
            default:                           w_next = IDLE;
        endcase
    end

    // Pointer starts at NREQ-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req   <= '0;
            r_grant <= '0;
            r_ptr   <= GW'(NREQ - 1);
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_req.daddr <= req_daddr_i[w_pick];
                r_req.addr  <= req_addr_i[w_pick];
                r_req.data  <= req_data_i[w_pick];
                r_req.wen   <= req_wen_i[w_pick];
                r_grant     <= w_pick;
            end
            if (r_state == WAIT && m_val_i) begin
                r_err  <= m_err_i;
                r_data <= m_data_i;
            end
            if (r_state == RESP && rsp_rdy_i[r_grant]) begin
                r_ptr <= r_grant;
            end
        end
    end

    always_comb begin
        req_rdy_o  = '0;
        rsp_val_o  = '0;
        rsp_err_o  = 1'b0;
        rsp_data_o = '0;
        if (r_state == IDLE && w_any) begin
            req_rdy_o[w_pick] = 1'b1;
        end
        if (r_state == RESP) begin
            rsp_val_o[r_grant] = 1'b1;
            rsp_err_o          = r_err;
            rsp_data_o         = r_data;
        end
        m_val_o   = (r_state == ISSUE);
        m_daddr_o = r_req.daddr;
        m_addr_o  = r_req.addr;
        m_data_o  = r_req.data;
        m_wen_o   = r_req.wen;
        m_rdy_o   = (r_state == WAIT);
        busy_o    = (r_state != IDLE);
        grant_o   = r_grant;
    end

endmodule

// File: tb/tb_i2c_arb.sv
// Self-checking bench for i2c_arb: transaction-level model, directed scenarios, randomized traffic.
// Expectations follow I2C_ARB_RETRY_EN when it is defined for the build.
module tb_i2c_arb;
    import i2c_pkg::*;

    localparam int NREQ      = 4;
    localparam int MAX_RETRY = 3;
    localparam int GW        = 2;
`ifdef I2C_ARB_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [NREQ-1:0]      req_val_i = '0;
    logic [NREQ-1:0][6:0] req_daddr_i = '0;
    logic [NREQ-1:0][7:0] req_addr_i = '0;
    logic [NREQ-1:0][7:0] req_data_i = '0;
    logic [NREQ-1:0]      req_wen_i = '0;
    logic [NREQ-1:0]      req_rdy_o;
    logic [NREQ-1:0]      rsp_val_o;
    logic                 rsp_err_o;
    logic [7:0]           rsp_data_o;
    logic [NREQ-1:0]      rsp_rdy_i = '0;
    logic                 m_val_o;
    logic [6:0]           m_daddr_o;
    logic [7:0]           m_addr_o;
    logic [7:0]           m_data_o;
    logic                 m_wen_o;
    logic                 m_rdy_i = 1'b0;
    logic                 m_val_i = 1'b0;
    logic                 m_err_i = 1'b0;
    logic [7:0]           m_data_i = '0;
    logic                 m_rdy_o;
    logic                 busy_o;
    logic [GW-1:0]        grant_o;

    i2c_arb #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_val_i   (req_val_i),
        .req_daddr_i (req_daddr_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_wen_i   (req_wen_i),
        .req_rdy_o   (req_rdy_o),
        .rsp_val_o   (rsp_val_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_rdy_i   (rsp_rdy_i),
        .m_val_o     (m_val_o),
        .m_daddr_o   (m_daddr_o),
        .m_addr_o    (m_addr_o),
        .m_data_o    (m_data_o),
        .m_wen_o     (m_wen_o),
        .m_rdy_i     (m_rdy_i),
        .m_val_i     (m_val_i),
        .m_err_i     (m_err_i),
        .m_data_i    (m_data_i),
        .m_rdy_o     (m_rdy_o),
        .busy_o      (busy_o),
        .grant_o     (grant_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- master responder ----------------
    logic [0:0] err_q[$];
    logic [7:0] data_q[$];
    bit         mst_pending = 1'b0;
    bit         mst_hold = 1'b0;
    int         issue_cnt = 0;

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            m_rdy_i = 1'b0;
            m_val_i = 1'b0;
            if (!rst_ni) begin
                mst_pending = 1'b0;
            end else if (mst_pending) begin
                if (!mst_hold && $urandom_range(0, 2) == 0) begin
                    m_val_i  = 1'b1;
                    m_err_i  = (err_q.size() > 0) ? err_q.pop_front() : 1'($urandom_range(0, 1));
                    m_data_i = (data_q.size() > 0) ? data_q.pop_front() : 8'($urandom);
                    mst_pending = 1'b0;
                end
            end else if (m_val_o && $urandom_range(0, 1) == 0) begin
                m_rdy_i     = 1'b1;
                mst_pending = 1'b1;
                issue_cnt++;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    bit         md_active, md_issue, md_fly, md_resp, md_err, md_wen;
    int         md_ptr = NREQ - 1;
    int         md_grant, md_att;
    logic [6:0] md_daddr;
    logic [7:0] md_addr, md_data, md_rdata;
    int         grant_log[$];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 1; i <= NREQ; i++) begin
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk_i) begin : p_cmp
        logic [NREQ-1:0] e_rdy, e_rsp;
        int pk;
        if (!rst_ni) begin
            chk("rst_busy", {31'd0, busy_o}, 0);
            chk("rst_req_rdy", {28'd0, req_rdy_o}, 0);
            chk("rst_rsp_val", {28'd0, rsp_val_o}, 0);
            chk("rst_m_val", {31'd0, m_val_o}, 0);
            chk("rst_m_rdy", {31'd0, m_rdy_o}, 0);
            chk("rst_grant", {30'd0, grant_o}, 0);
            md_active = 0; md_issue = 0; md_fly = 0; md_resp = 0;
            md_ptr = NREQ - 1; md_grant = 0; md_att = 0;
        end else begin
            pk = md_active ? -1 : rr_pick(req_val_i, md_ptr);
            e_rdy = '0;
            if (pk >= 0) e_rdy[pk] = 1'b1;
            e_rsp = '0;
            if (md_resp) e_rsp[md_grant] = 1'b1;
            chk("req_rdy", {28'd0, req_rdy_o}, {28'd0, e_rdy});
            chk("busy", {31'd0, busy_o}, {31'd0, md_active});
            chk("grant", {30'd0, grant_o}, md_grant);
            chk("m_val", {31'd0, m_val_o}, {31'd0, md_issue});
            chk("m_rdy", {31'd0, m_rdy_o}, {31'd0, md_fly});
            chk("rsp_val", {28'd0, rsp_val_o}, {28'd0, e_rsp});
            if (md_issue) begin
                chk("m_fields", {m_daddr_o, m_addr_o, m_data_o, m_wen_o},
                    {md_daddr, md_addr, md_data, md_wen});
            end
            if (md_resp) begin
                chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, md_err});
                if (!md_wen) chk("rsp_data", {24'd0, rsp_data_o}, {24'd0, md_rdata});
            end
            // Advance the model by the handshakes that complete at the coming edge.
            if (pk >= 0) begin
                grant_log.push_back(pk);
                md_active = 1; md_issue = 1; md_grant = pk; md_att = 0;
                md_daddr = req_daddr_i[pk]; md_addr = req_addr_i[pk];
                md_data = req_data_i[pk]; md_wen = req_wen_i[pk];
            end else if (md_issue) begin
                if (m_rdy_i) begin
                    md_issue = 0; md_fly = 1; md_att++;
                end
            end else if (md_fly) begin
                if (m_val_i) begin
                    md_fly = 0;
                    if (m_err_i && RETRY_EN && (md_att - 1) < MAX_RETRY) begin
                        md_issue = 1;
                    end else begin
                        md_resp = 1; md_err = m_err_i; md_rdata = m_data_i;
                    end
                end
            end else if (md_resp && rsp_rdy_i[md_grant]) begin
                md_resp = 0; md_active = 0; md_ptr = md_grant;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [6:0] da, input logic [7:0] a,
                           input logic [7:0] d, input logic w);
        req_daddr_i[i] = da; req_addr_i[i] = a; req_data_i[i] = d; req_wen_i[i] = w;
    endtask

    task automatic wait_accept(output int idx);
        bit got = 0;
        idx = -1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk_i);
            for (int i = 0; i < NREQ; i++) if (req_rdy_o[i]) begin idx = i; got = 1; end
        end
        chk("accept_seen", {31'd0, got}, 1);
    endtask

    task automatic wait_rsp(output logic [NREQ-1:0] v, output logic e, output logic [7:0] d);
        bit got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk_i);
            if (rsp_val_o != '0) got = 1;
        end
        chk("rsp_seen", {31'd0, got}, 1);
        v = rsp_val_o; e = rsp_err_o; d = rsp_data_o;
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk_i);
            if (!busy_o) got = 1;
        end
        chk("idle_seen", {31'd0, got}, 1);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0; req_val_i = '0; rsp_rdy_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic run_nack(input string tag, input logic last_err,
                            input int exp_pulses, input logic exp_err);
        int idx, c0;
        logic [NREQ-1:0] v; logic e; logic [7:0] d;
        err_q.delete();
        err_q.push_back(1'b1); err_q.push_back(1'b1); err_q.push_back(1'b1);
        err_q.push_back(last_err);
        c0 = issue_cnt;
        @(posedge clk_i); #1;
        set_req(3, 7'h2A, 8'h11, 8'h00, 1'b0);
        req_val_i = 4'b1000; rsp_rdy_i = 4'b1000;
        wait_accept(idx);
        @(posedge clk_i); #1 req_val_i = '0;
        wait_rsp(v, e, d);
        chk({tag, "_rsp_val"}, {28'd0, v}, 32'b1000);
        chk({tag, "_pulses"}, issue_cnt - c0, exp_pulses);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        wait_idle();
        err_q.delete();
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_i); #1;
            for (int i = 0; i < NREQ; i++) begin
                req_val_i[i] = ($urandom_range(0, 9) < 6);
                set_req(i, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end
            rsp_rdy_i = 4'($urandom);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idx, base;
        logic [NREQ-1:0] v; logic e; logic [7:0] d;

        do_reset();

        // 1: single write from requester 0
        err_q.push_back(1'b0);
        set_req(0, 7'h50, 8'h10, 8'hA5, 1'b1);
        req_val_i = 4'b0001; rsp_rdy_i = 4'b0001;
        wait_accept(idx);
        chk("t1_grant", idx, 0);
        @(posedge clk_i); #1 req_val_i = '0;
        @(negedge clk_i);
        chk("t1_m_val", {31'd0, m_val_o}, 1);
        chk("t1_m_fields", {m_daddr_o, m_addr_o, m_data_o, m_wen_o}, {7'h50, 8'h10, 8'hA5, 1'b1});
        wait_rsp(v, e, d);
        chk("t1_rsp_val", {28'd0, v}, 32'b0001);
        chk("t1_rsp_err", {31'd0, e}, 0);
        wait_idle();

        // 2: read from requester 1
        err_q.push_back(1'b0); data_q.push_back(8'h3C);
        @(posedge clk_i); #1;
        set_req(1, 7'h68, 8'h03, 8'h00, 1'b0);
        req_val_i = 4'b0010; rsp_rdy_i = 4'b0010;
        wait_accept(idx);
        @(posedge clk_i); #1 req_val_i = '0;
        wait_rsp(v, e, d);
        chk("t2_rsp_val", {28'd0, v}, 32'b0010);
        chk("t2_rsp_data", {24'd0, d}, 32'h3C);
        chk("t2_rsp_err", {31'd0, e}, 0);
        wait_idle();
        data_q.delete();

        // 3: all requesters valid from reset -> rotation 0,1,2,3,0
        do_reset();
        base = grant_log.size();
        req_val_i = 4'b1111; rsp_rdy_i = 4'b1111;
        for (int n = 0; n < 1000 && grant_log.size() < base + 5; n++) @(negedge clk_i);
        chk("t3_count", grant_log.size() - base, 5);
        if (grant_log.size() >= base + 5) begin
            chk("t3_order0", grant_log[base + 0], 0);
            chk("t3_order1", grant_log[base + 1], 1);
            chk("t3_order2", grant_log[base + 2], 2);
            chk("t3_order3", grant_log[base + 3], 3);
            chk("t3_order4", grant_log[base + 4], 0);
        end
        @(posedge clk_i); #1 req_val_i = '0;
        wait_idle();

        // 4: response back-pressure on requester 2 while requester 0 waits
        @(posedge clk_i); #1;
        set_req(2, 7'h33, 8'h44, 8'h55, 1'b1);
        req_val_i = 4'b0100; rsp_rdy_i = '0;
        wait_accept(idx);
        chk("t4_grant", idx, 2);
        @(posedge clk_i); #1;
        req_val_i = 4'b0001; rsp_rdy_i = 4'b1011;
        wait_rsp(v, e, d);
        chk("t4_rsp_val", {28'd0, v}, 32'b0100);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_i);
            chk("t4_hold_rsp", {28'd0, rsp_val_o}, 32'b0100);
            chk("t4_hold_rdy", {28'd0, req_rdy_o}, 0);
        end
        @(posedge clk_i); #1 rsp_rdy_i = 4'b0100;
        wait_accept(idx);
        chk("t4_next_grant", idx, 0);
        @(posedge clk_i); #1;
        req_val_i = '0; rsp_rdy_i = 4'b1111;
        wait_idle();

        // 5: NACK handling
        run_nack("t5_recover", 1'b0, RETRY_EN ? 4 : 1, RETRY_EN ? 1'b0 : 1'b1);
        run_nack("t5_exhaust", 1'b1, RETRY_EN ? 4 : 1, 1'b1);

        // 6: asynchronous reset while waiting on the master
        mst_hold = 1'b1;
        @(posedge clk_i); #1;
        set_req(1, 7'h12, 8'h34, 8'h56, 1'b1);
        req_val_i = 4'b0010;
        begin
            bit got = 0;
            for (int n = 0; n < 300 && !got; n++) begin
                @(negedge clk_i);
                if (m_rdy_o) got = 1;
            end
            chk("t6_wait_seen", {31'd0, got}, 1);
        end
        @(posedge clk_i);
        #1 req_val_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy_o}, 0);
        chk("t6_rsp_val", {28'd0, rsp_val_o}, 0);
        chk("t6_m_rdy", {31'd0, m_rdy_o}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        mst_hold = 1'b0; rst_ni = 1'b1;
        req_val_i = 4'b1111; rsp_rdy_i = 4'b1111;
        wait_accept(idx);
        chk("t6_first_grant", idx, 0);
        @(posedge clk_i); #1 req_val_i = '0;
        wait_idle();

        // randomized traffic against the model
        run_random(4000);
        @(posedge clk_i); #1;
        req_val_i = '0; rsp_rdy_i = 4'b1111;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
